// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared definitions for the FIFO write-port arbiter:
//     arb_state_t - arbiter FSM encoding (IDLE / GRANT)
//     STATS_W     - width of the optional per-requester beat counters
//     id_width()  - bit width needed to index N items (never below 1)
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int STATS_W = 16;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Returns the first set bit of req,
//   searching upward from last_id+1 and wrapping modulo N_REQ, so the
//   requester named by last_id is considered last.
// Ports:
//   req      in  N_REQ  request vector
//   last_id  in  ID_W   most recently served requester
//   next_id  out ID_W   selected requester (0 when no request)
//   any_req  out 1      at least one request bit is set
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]           req,
    input  logic [id_width(N_REQ)-1:0] last_id,
    output logic [id_width(N_REQ)-1:0] next_id,
    output logic                       any_req
);

    localparam int ID_W = id_width(N_REQ);

    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        next_id = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((int'(last_id) + k) % N_REQ);
            if (!found && req[idx]) begin
                found   = 1'b1;
                next_id = idx;
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares one FIFO write port among N_REQ valid/ready requesters using
//   round-robin arbitration with bursts of at most MAX_BURST beats. One
//   arbitration cycle (IDLE) separates consecutive grants. fifo_full stalls
//   the granted requester without releasing its grant.
// Ports:
//   clk         in   write-domain clock
//   rst         in   asynchronous active-high reset
//   src_valid   in   N_REQ        per-requester valid
//   src_data    in   N_REQ*WIDTH  requester i at [i*WIDTH +: WIDTH]
//   src_ready   out  N_REQ        per-requester accept (at most one high)
//   fifo_full   in   FIFO full flag
//   wr_en       out  FIFO write enable
//   wr_data     out  WIDTH        FIFO write data (don't-care when !wr_en)
//   gnt_valid   out  a grant is held
//   gnt_id      out  index of the granted requester
// Optional (macro FIFO_ARB_STATS_EN):
//   stats_clr   in   synchronous clear of all beat counters
//   beat_cnt_o  out  N_REQ*16     saturating accepted-beat counters
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           src_valid,
    input  logic [N_REQ*WIDTH-1:0]     src_data,
    output logic [N_REQ-1:0]           src_ready,
    input  logic                       fifo_full,
    output logic                       wr_en,
    output logic [WIDTH-1:0]           wr_data,
    output logic                       gnt_valid,
    output logic [id_width(N_REQ)-1:0] gnt_id
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic                       stats_clr,
    output logic [N_REQ*STATS_W-1:0]   beat_cnt_o
`endif
);

    localparam int ID_W = id_width(N_REQ);
    localparam int BC_W = id_width(MAX_BURST);

    arb_state_t      state, state_nxt;
    logic [ID_W-1:0] gnt_id_nxt;
    logic [ID_W-1:0] last_id, last_id_nxt;
    logic [ID_W-1:0] pick_id;
    logic [BC_W-1:0] beat_cnt, beat_cnt_nxt;
    logic            any_req;
    logic            sel_valid;
    logic [WIDTH-1:0] src_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign src_arr[i] = src_data[i*WIDTH +: WIDTH];
    end

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req     (src_valid),
        .last_id (last_id),
        .next_id (pick_id),
        .any_req (any_req)
    );

    assign sel_valid = src_valid[gnt_id];
    assign wr_data   = src_arr[gnt_id];
    assign gnt_valid = (state == GRANT);

    // last_id resets to the top index so requester 0 wins the first arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt_id   <= '0;
            last_id  <= ID_W'(N_REQ - 1);
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            gnt_id   <= gnt_id_nxt;
            last_id  <= last_id_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        gnt_id_nxt   = gnt_id;
        last_id_nxt  = last_id;
        beat_cnt_nxt = beat_cnt;
        src_ready    = '0;
        wr_en        = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    gnt_id_nxt   = pick_id;
                    beat_cnt_nxt = '0;
                    state_nxt    = GRANT;
                end
            end
            GRANT: begin
                src_ready[gnt_id] = !fifo_full;
                wr_en             = sel_valid && !fifo_full;
                if (wr_en) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                end
                // A stalled beat (fifo_full) neither counts nor releases;
                // a dropped valid releases immediately.
                if ((wr_en && beat_cnt == BC_W'(MAX_BURST - 1)) || !sel_valid) begin
                    last_id_nxt = gnt_id;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef FIFO_ARB_STATS_EN
    for (genvar i = 0; i < N_REQ; i++) begin : g_stats
        logic [STATS_W-1:0] cnt;

        // Clear wins over a same-cycle increment; counters stick at all-ones.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (stats_clr) begin
                cnt <= '0;
            end else if (wr_en && gnt_id == ID_W'(i) && cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign beat_cnt_o[i*STATS_W +: STATS_W] = cnt;
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Self-checking bench for fifo_wr_arbiter (N_REQ=4, MAX_BURST=4, WIDTH=8):
//   directed scenarios followed by randomized traffic checked against a
//   cycle-level reference model. With FIFO_ARB_STATS_EN defined, a second
//   instance exercises the beat counters.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int MB = 4;
    localparam int W  = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] vld;
    logic [W-1:0] dat [N];
    logic [N*W-1:0] src_data;
    logic         full;
    logic [N-1:0] src_ready;
    logic         wr_en;
    logic [W-1:0] wr_data;
    logic         gnt_valid;
    logic [1:0]   gnt_id;

    int n_tests = 0;
    int n_fail  = 0;

    int pat1_we [8] = '{0, 1, 1, 1, 1, 0, 1, 1};
    int pat3_we [9] = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
    int pat3_gv [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign src_data[g*W +: W] = dat[g];
    end

`ifdef FIFO_ARB_STATS_EN
    logic          m_clr = 1'b0;
    logic [N*16-1:0] m_cnt;
    logic [1:0]    s_vld;
    logic [15:0]   s_src_data;
    logic          s_clr;
    logic [1:0]    s_rdy;
    logic          s_we;
    logic [W-1:0]  s_wd;
    logic          s_gv;
    logic [0:0]    s_gid;
    logic [31:0]   s_cnt;

    fifo_wr_arbiter #(
        .WIDTH (W), .N_REQ (2), .MAX_BURST (256)
    ) dut_s (
        .clk (clk), .rst (rst), .src_valid (s_vld), .src_data (s_src_data),
        .src_ready (s_rdy), .fifo_full (1'b0), .wr_en (s_we), .wr_data (s_wd),
        .gnt_valid (s_gv), .gnt_id (s_gid), .stats_clr (s_clr), .beat_cnt_o (s_cnt)
    );
`endif

    fifo_wr_arbiter #(
        .WIDTH (W), .N_REQ (N), .MAX_BURST (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (vld),
        .src_data  (src_data),
        .src_ready (src_ready),
        .fifo_full (full),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stats_clr  (m_clr),
        .beat_cnt_o (m_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        vld  = '0;
        full = 1'b0;
        for (int i = 0; i < N; i++) dat[i] = '0;
`ifdef FIFO_ARB_STATS_EN
        s_vld = '0;
        s_src_data = '0;
        s_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int d;
        int beats;
        int acc_id;
        int owner, last, mbeats, accepted;
        int seq [N];
        logic e_we;
        logic [N-1:0] e_rdy;

        // Reset state, even with every requester asking.
        rst  = 1'b1;
        full = 1'b0;
        for (int i = 0; i < N; i++) dat[i] = '0;
        vld  = '1;
`ifdef FIFO_ARB_STATS_EN
        s_vld = '0;
        s_src_data = '0;
        s_clr = 1'b0;
`endif
        @(negedge clk);
        check_eq("rst_gv", gnt_valid, 0);
        check_eq("rst_we", wr_en, 0);
        check_eq("rst_rdy", src_ready, 0);
        check_eq("rst_gid", gnt_id, 0);

        // Single requester: bursts of 4, one idle cycle, then regrant.
        do_reset();
        d = 1;
        for (int c = 0; c < 8; c++) begin
            vld = (d <= 6) ? 4'b0001 : 4'b0000;
            dat[0] = 8'(d);
            @(negedge clk);
            check_eq("t1_we", wr_en, pat1_we[c]);
            check_eq("t1_gv", gnt_valid, pat1_we[c]);
            if (wr_en) check_eq("t1_data", wr_data, d);
            e_we = wr_en;
            next_cycle();
            if (e_we) d++;
        end
        check_eq("t1_total", d, 7);

        // All requesters active: 0x4, 1x4, 2x4, 3x4, 0 ... with one idle cycle between.
        do_reset();
        vld = '1;
        for (int i = 0; i < N; i++) begin
            seq[i] = 0;
            dat[i] = 8'(i * 64);
        end
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            check_eq("t2_we", wr_en, ((c % 5) != 0) ? 1 : 0);
            acc_id = -1;
            if (wr_en) begin
                check_eq("t2_id", wr_data[7:6], (c / 5) % N);
                acc_id = int'(wr_data[7:6]);
                check_eq("t2_seq", wr_data[5:0], seq[acc_id]);
            end
            next_cycle();
            if (acc_id >= 0) begin
                seq[acc_id]++;
                dat[acc_id] = 8'(acc_id * 64 + seq[acc_id]);
            end
        end
        vld = '0;

        // fifo_full stall mid-burst of requester 2.
        do_reset();
        vld = 4'b0100;
        d = 0;
        dat[2] = 8'(128);
        for (int c = 0; c < 9; c++) begin
            full = (c >= 3 && c <= 5);
            @(negedge clk);
            check_eq("t3_we", wr_en, pat3_we[c]);
            check_eq("t3_gv", gnt_valid, pat3_gv[c]);
            if (full) check_eq("t3_rdy_stall", src_ready, 0);
            if (gnt_valid) check_eq("t3_gid", gnt_id, 2);
            e_we = wr_en;
            next_cycle();
            if (e_we) begin
                d++;
                dat[2] = 8'(128 + d);
            end
        end
        check_eq("t3_total", d, 4);
        vld  = '0;
        full = 1'b0;

        // Requester 1 drops valid after one beat while 3 waits: 3 wins next.
        do_reset();
        vld = 4'b1010;
        @(negedge clk);
        check_eq("t4_idle", gnt_valid, 0);
        next_cycle();
        @(negedge clk);
        check_eq("t4_gid1", gnt_id, 1);
        check_eq("t4_we1", wr_en, 1);
        next_cycle();
        vld = 4'b1000;
        @(negedge clk);
        check_eq("t4_drop_we", wr_en, 0);
        check_eq("t4_drop_rdy", src_ready, 4'b0010);
        next_cycle();
        @(negedge clk);
        check_eq("t4_rel_gv", gnt_valid, 0);
        next_cycle();
        @(negedge clk);
        check_eq("t4_gid3", gnt_id, 3);
        check_eq("t4_we3", wr_en, 1);
        next_cycle();
        vld = '0;

        // Reset pulse in the middle of a granted beat.
        do_reset();
        vld = 4'b0010;
        next_cycle();
        @(negedge clk);
        check_eq("t5_we_pre", wr_en, 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t5_we_rst", wr_en, 0);
        check_eq("t5_rdy_rst", src_ready, 0);
        check_eq("t5_gv_rst", gnt_valid, 0);
        check_eq("t5_gid_rst", gnt_id, 0);
        next_cycle();
        rst = 1'b0;
        vld = 4'b0011;
        @(negedge clk);
        check_eq("t5_idle", gnt_valid, 0);
        next_cycle();
        @(negedge clk);
        check_eq("t5_gid0", gnt_id, 0);
        check_eq("t5_gv", gnt_valid, 1);
        next_cycle();
        vld = '0;

        // Randomized traffic against the reference model.
        do_reset();
        owner  = -1;
        last   = N - 1;
        mbeats = 0;
        for (int i = 0; i < N; i++) begin
            seq[i] = 0;
            dat[i] = 8'(i * 64);
        end
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            e_rdy = (owner >= 0 && !full) ? N'(1 << owner) : '0;
            e_we  = (owner >= 0) && vld[owner] && !full;
            check_eq("rnd_gv", gnt_valid, (owner >= 0) ? 1 : 0);
            if (owner >= 0) check_eq("rnd_gid", gnt_id, owner);
            check_eq("rnd_rdy", src_ready, e_rdy);
            check_eq("rnd_we", wr_en, e_we);
            if (e_we) check_eq("rnd_data", wr_data, dat[owner]);
            accepted = e_we ? owner : -1;
            if (owner < 0) begin
                for (int k = 1; k <= N; k++) begin
                    if (owner < 0 && vld[(last + k) % N]) owner = (last + k) % N;
                end
                mbeats = 0;
            end else begin
                if (e_we) mbeats++;
                if ((e_we && mbeats == MB) || !vld[owner]) begin
                    last  = owner;
                    owner = -1;
                end
            end
            next_cycle();
            for (int i = 0; i < N; i++) begin
                if (i == accepted) begin
                    seq[i] = (seq[i] + 1) % 64;
                    dat[i] = 8'(i * 64 + seq[i]);
                    vld[i] = ($urandom_range(3) != 0);
                end else if (vld[i]) begin
                    if ($urandom_range(9) == 0) vld[i] = 1'b0;
                end else begin
                    vld[i] = ($urandom_range(2) == 0);
                end
            end
            full = ($urandom_range(3) == 0);
        end
        vld  = '0;
        full = 1'b0;

`ifdef FIFO_ARB_STATS_EN
        // Beat counters: clear beats a same-cycle increment, then saturate.
        do_reset();
        s_vld = 2'b01;
        repeat (5) next_cycle();
        s_clr = 1'b1;
        @(negedge clk);
        check_eq("st_clr_beat", s_we, 1);
        next_cycle();
        s_clr = 1'b0;
        @(negedge clk);
        check_eq("st_clr", s_cnt[15:0], 0);
        beats = 0;
        for (int c = 0; c < 75000 && beats < 70000; c++) begin
            if (s_we) beats++;
            next_cycle();
            @(negedge clk);
        end
        check_eq("st_budget", beats, 70000);
        s_vld = '0;
        next_cycle();
        @(negedge clk);
        check_eq("st_sat", s_cnt[15:0], 16'hFFFF);
        check_eq("st_other", s_cnt[31:16], 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
